// File: rtl/tipi_pkg.sv
// Shared constants for the TIPI register block: default TI addresses,
// RPi register-select encoding and the RPi transfer FSM state type.
package tipi_pkg;

  localparam logic [15:0] TD_ADDR_DEF = 16'h5FFF;
  localparam logic [15:0] TC_ADDR_DEF = 16'h5FFD;
  localparam logic [15:0] RD_ADDR_DEF = 16'h5FFB;
  localparam logic [15:0] RC_ADDR_DEF = 16'h5FF9;

  localparam logic [1:0] RREG_TD = 2'd0;
  localparam logic [1:0] RREG_TC = 2'd1;
  localparam logic [1:0] RREG_RD = 2'd2;
  localparam logic [1:0] RREG_RC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rpi_state_e;

endpackage

// File: rtl/tipi_sync.sv
// Multi-flop synchronizer for one asynchronous strobe, with single-cycle
// rise/fall pulses derived from the synchronized level. STAGES must be >= 2.
module tipi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/tipi_reg_ctrl.sv
// TIPI register block: four 8-bit mailbox registers shared between the TI bus
// (parallel, asynchronous) and the RPi (serial shift port), all in clk domain.
module tipi_reg_ctrl
  import tipi_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] TD_ADDR     = TD_ADDR_DEF,
  parameter logic [15:0] TC_ADDR     = TC_ADDR_DEF,
  parameter logic [15:0] RD_ADDR     = RD_ADDR_DEF,
  parameter logic [15:0] RC_ADDR     = RC_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] ti_a,
  input  logic [7:0]  ti_data,
  input  logic        ti_memen,
  input  logic        ti_we,
  input  logic        ti_dbin,
  input  logic        cru_en,
  input  logic        r_clk,
  input  logic        r_le,
  input  logic        r_din,
  input  logic [1:0]  r_reg,
  output logic        r_dout,
  output logic [7:0]  td_q,
  output logic [7:0]  tc_q,
  output logic [7:0]  rd_q,
  output logic [7:0]  rc_q,
  output logic [7:0]  ti_rd_data,
  output logic        ti_rd_oe,
  output logic [1:0]  ti_wr_stb,
  output logic [1:0]  dbg_state
);

  // Address, data and r_din travel through the same depth as the strobes so
  // they line up with the synchronized edge that qualifies them.
  logic [SYNC_STAGES-1:0][24:0] bus_pipe_q, bus_pipe_d;
  logic [15:0] a_s;
  logic [7:0]  data_s;
  logic        din_s;

  logic memen_s, dbin_s, we_fall, rclk_rise, le_rise;
  logic unused_memen_r, unused_memen_f, unused_dbin_r, unused_dbin_f;
  logic unused_we_q, unused_we_r, unused_rclk_q, unused_rclk_f;
  logic unused_le_q, unused_le_f;

  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_memen (
    .clk(clk), .rst_n(rst_n), .d(ti_memen),
    .q(memen_s), .rise(unused_memen_r), .fall(unused_memen_f));
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_we (
    .clk(clk), .rst_n(rst_n), .d(ti_we),
    .q(unused_we_q), .rise(unused_we_r), .fall(we_fall));
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dbin (
    .clk(clk), .rst_n(rst_n), .d(ti_dbin),
    .q(dbin_s), .rise(unused_dbin_r), .fall(unused_dbin_f));
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rclk (
    .clk(clk), .rst_n(rst_n), .d(r_clk),
    .q(unused_rclk_q), .rise(rclk_rise), .fall(unused_rclk_f));
  tipi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .d(r_le),
    .q(unused_le_q), .rise(le_rise), .fall(unused_le_f));

  rpi_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  td_d, tc_d, rd_d, rc_d, rdata_d;
  logic        r_dout_d, oe_d, wr_td, wr_tc, rd_hit;
  logic [1:0]  stb_d;

  always_comb begin
    bus_pipe_d = {bus_pipe_q[SYNC_STAGES-2:0], {ti_a, ti_data, r_din}};
    a_s        = bus_pipe_q[SYNC_STAGES-1][24:9];
    data_s     = bus_pipe_q[SYNC_STAGES-1][8:1];
    din_s      = bus_pipe_q[SYNC_STAGES-1][0];
  end

  always_comb begin
    td_d     = td_q;
    tc_d     = tc_q;
    rd_d     = rd_q;
    rc_d     = rc_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sel_d    = sel_q;
    r_dout_d = r_dout;

    wr_td  = we_fall && !memen_s && cru_en && (a_s == TD_ADDR);
    wr_tc  = we_fall && !memen_s && cru_en && (a_s == TC_ADDR);
    stb_d  = {wr_tc, wr_td};
    if (wr_td) td_d = data_s;
    if (wr_tc) tc_d = data_s;

    rd_hit  = !memen_s && dbin_s && cru_en && ((a_s == RD_ADDR) || (a_s == RC_ADDR));
    oe_d    = rd_hit;
    rdata_d = 8'h00;
    if (rd_hit) rdata_d = (a_s == RD_ADDR) ? rd_q : rc_q;

    case (state_q)
      ST_SHIFT: begin
        if (rclk_rise) begin
          r_dout_d = shift_q[7];
          shift_d  = {shift_q[6:0], din_s};
          cnt_d    = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (sel_q == RREG_RD) rd_d = shift_q;
        if (sel_q == RREG_RC) rc_d = shift_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A load reads the current register values, so a same-cycle TI write
    // is not seen by it; it also abandons any transfer in flight.
    if (le_rise) begin
      case (r_reg)
        RREG_TD: shift_d = td_q;
        RREG_TC: shift_d = tc_q;
        RREG_RD: shift_d = rd_q;
        default: shift_d = rc_q;
      endcase
      sel_d   = r_reg;
      cnt_d   = 4'd0;
      state_d = ST_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_pipe_q <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      sel_q      <= RREG_TD;
      r_dout     <= 1'b0;
      td_q       <= 8'h00;
      tc_q       <= 8'h00;
      rd_q       <= 8'h00;
      rc_q       <= 8'h00;
      ti_rd_data <= 8'h00;
      ti_rd_oe   <= 1'b0;
      ti_wr_stb  <= 2'b00;
    end else begin
      bus_pipe_q <= bus_pipe_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sel_q      <= sel_d;
      r_dout     <= r_dout_d;
      td_q       <= td_d;
      tc_q       <= tc_d;
      rd_q       <= rd_d;
      rc_q       <= rc_d;
      ti_rd_data <= rdata_d;
      ti_rd_oe   <= oe_d;
      ti_wr_stb  <= stb_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_tipi_reg_ctrl.sv
// Bench for tipi_reg_ctrl: directed scenarios plus random TI/RPi traffic,
// checked by scoreboards fed from a behavioural mailbox model.
module tb_tipi_reg_ctrl;
  import tipi_pkg::*;

  localparam logic [15:0] A_TD = 16'h5FFF;
  localparam logic [15:0] A_TC = 16'h5FFD;
  localparam logic [15:0] A_RD = 16'h5FFB;
  localparam logic [15:0] A_RC = 16'h5FF9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:15] ti_a = 16'h0000;
  logic [7:0]  ti_data = 8'h00;
  logic        ti_memen = 1'b1, ti_we = 1'b1, ti_dbin = 1'b0, cru_en = 1'b1;
  logic        r_clk = 1'b0, r_le = 1'b0, r_din = 1'b0;
  logic [1:0]  r_reg = 2'd0;
  logic        r_dout;
  logic [7:0]  td_q, tc_q, rd_q, rc_q, ti_rd_data;
  logic        ti_rd_oe;
  logic [1:0]  ti_wr_stb, dbg_state;

  tipi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ti_a(ti_a), .ti_data(ti_data),
    .ti_memen(ti_memen), .ti_we(ti_we), .ti_dbin(ti_dbin), .cru_en(cru_en),
    .r_clk(r_clk), .r_le(r_le), .r_din(r_din), .r_reg(r_reg), .r_dout(r_dout),
    .td_q(td_q), .tc_q(tc_q), .rd_q(rd_q), .rc_q(rc_q),
    .ti_rd_data(ti_rd_data), .ti_rd_oe(ti_rd_oe), .ti_wr_stb(ti_wr_stb),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- model and scoreboards ----------------
  int checks = 0;
  int failures = 0;

  logic [7:0] m_reg [4];          // index = r_reg encoding: TD, TC, RD, RC
  bit         m_busy;
  int         m_cnt;
  logic [1:0] m_sel;
  logic [7:0] m_acc;

  logic [9:0] wr_exp_q[$];        // {strobe bits, value written}
  logic [7:0] rd_exp_q[$];
  logic [0:0] dout_exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_td"}, {8'h00, td_q}, {8'h00, m_reg[0]});
    check({tag, "_tc"}, {8'h00, tc_q}, {8'h00, m_reg[1]});
    check({tag, "_rd"}, {8'h00, rd_q}, {8'h00, m_reg[2]});
    check({tag, "_rc"}, {8'h00, rc_q}, {8'h00, m_reg[3]});
  endtask

  // Write-strobe monitor: every nonzero strobe cycle must match one expected write.
  always @(negedge clk) begin
    if (rst_n && ti_wr_stb != 2'b00) begin
      if (wr_exp_q.size() == 0) begin
        check("wr_stb_unexpected", {14'h0, ti_wr_stb}, 16'h0);
      end else begin
        logic [9:0] e;
        e = wr_exp_q.pop_front();
        check("wr_stb_event", {6'h0, ti_wr_stb, (ti_wr_stb[0] ? td_q : tc_q)}, {6'h0, e});
      end
    end
  end

  // Read monitor: the first cycle of each output-enable window carries the data.
  logic prev_oe = 1'b0;
  always @(negedge clk) begin
    if (ti_rd_oe && !prev_oe) begin
      if (rd_exp_q.size() == 0) begin
        check("rd_oe_unexpected", {15'h0, ti_rd_oe}, 16'h0);
      end else begin
        logic [7:0] e;
        e = rd_exp_q.pop_front();
        check("rd_data", {8'h00, ti_rd_data}, {8'h00, e});
      end
    end
    prev_oe = ti_rd_oe;
  end

  // Serial-out monitor: r_dout is sampled as the RPi drops its shift clock.
  always @(negedge r_clk) begin
    if (dout_exp_q.size() != 0) begin
      logic [0:0] e;
      e = dout_exp_q.pop_front();
      check("r_dout_bit", {15'h0, r_dout}, {15'h0, e});
    end
  end

  // ---------------- drivers ----------------
  task automatic ti_write(input logic [15:0] addr, input logic [7:0] data, input logic cru);
    if (cru && addr == A_TD) begin
      m_reg[0] = data;
      wr_exp_q.push_back({2'b01, data});
    end else if (cru && addr == A_TC) begin
      m_reg[1] = data;
      wr_exp_q.push_back({2'b10, data});
    end
    ti_a = addr; ti_data = data; cru_en = cru; ti_memen = 1'b0;
    repeat (4) @(negedge clk);
    ti_we = 1'b0;
    repeat (5) @(negedge clk);
    ti_we = 1'b1;
    repeat (3) @(negedge clk);
    ti_memen = 1'b1;
    repeat (4) @(negedge clk);
    cru_en = 1'b1;
  endtask

  task automatic ti_read(input logic [15:0] addr, input logic cru);
    if (cru && addr == A_RD) rd_exp_q.push_back(m_reg[2]);
    else if (cru && addr == A_RC) rd_exp_q.push_back(m_reg[3]);
    ti_a = addr; cru_en = cru; ti_memen = 1'b0; ti_dbin = 1'b1;
    repeat (6) @(negedge clk);
    ti_dbin = 1'b0; ti_memen = 1'b1;
    repeat (4) @(negedge clk);
    cru_en = 1'b1;
  endtask

  // Optional load, then npulses bits of din, MSB first.
  task automatic rpi_xfer(input logic [1:0] sel, input logic [7:0] din,
                          input int npulses, input bit do_load);
    r_reg = sel;
    if (do_load) begin
      m_acc  = m_reg[sel];
      m_sel  = sel;
      m_cnt  = 0;
      m_busy = 1'b1;
      r_le = 1'b1;
      repeat (5) @(negedge clk);
      r_le = 1'b0;
      repeat (5) @(negedge clk);
    end
    for (int i = 0; i < npulses; i++) begin
      r_din = din[7-i];
      if (m_busy) begin
        dout_exp_q.push_back(m_acc[7]);
        m_acc = {m_acc[6:0], din[7-i]};
        m_cnt++;
      end
      repeat (2) @(negedge clk);
      r_clk = 1'b1;
      repeat (5) @(negedge clk);
      r_clk = 1'b0;
      repeat (5) @(negedge clk);
      if (m_busy && m_cnt == 8) begin
        if (m_sel == RREG_RD || m_sel == RREG_RC) m_reg[m_sel] = m_acc;
        m_busy = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_regs("reset");
    check("reset_rd_data", {8'h00, ti_rd_data}, 16'h0000);
    check("reset_rd_oe", {15'h0, ti_rd_oe}, 16'h0000);
    check("reset_r_dout", {15'h0, r_dout}, 16'h0000);
    check("reset_wr_stb", {14'h0, ti_wr_stb}, 16'h0000);
    check("reset_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    ti_write(A_TD, 8'hA5, 1'b1);
    check_regs("td_write");

    ti_write(A_TC, 8'h3C, 1'b0);
    check_regs("tc_write_disabled");
    ti_write(A_TC, 8'h3C, 1'b1);
    check_regs("tc_write");

    rpi_xfer(RREG_RD, 8'h81, 8, 1'b1);
    check_regs("rd_commit");
    check("rd_commit_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
    ti_read(A_RD, 1'b1);

    ti_write(A_TD, 8'hC3, 1'b1);
    rpi_xfer(RREG_TD, 8'h5A, 8, 1'b1);
    check_regs("td_readout");

    rpi_xfer(RREG_RC, 8'h55, 4, 1'b1);
    check("abort_mid_state", {14'h0, dbg_state}, {14'h0, ST_SHIFT});
    rpi_xfer(RREG_RC, 8'h00, 0, 1'b1);
    check("abort_reload_state", {14'h0, dbg_state}, {14'h0, ST_SHIFT});
    check_regs("abort_reload");
    rpi_xfer(RREG_RC, 8'hE7, 8, 1'b0);
    check_regs("rc_commit");
    ti_read(A_RC, 1'b1);

    ti_read(A_RC, 1'b0);
    ti_read(A_TD, 1'b1);
    ti_write(16'h1234, 8'h99, 1'b1);
    check_regs("ignored_ops");

    rpi_xfer(RREG_RC, 8'h66, 4, 1'b1);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_abort_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
    check("reset_abort_dout", {15'h0, r_dout}, 16'h0000);
    rpi_xfer(RREG_RC, 8'hFF, 5, 1'b0);
    check("idle_clk_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
    check_regs("reset_abort");

    for (int n = 0; n < 30; n++) begin
      int op;
      logic [15:0] addrs [5];
      addrs[0] = A_TD; addrs[1] = A_TC; addrs[2] = A_RD; addrs[3] = A_RC; addrs[4] = 16'h1234;
      op = $urandom_range(0, 2);
      case (op)
        0: ti_write(addrs[$urandom_range(0, 4)], 8'($urandom), 1'($urandom_range(0, 3) != 0));
        1: ti_read(addrs[$urandom_range(0, 4)], 1'($urandom_range(0, 3) != 0));
        default: rpi_xfer(2'($urandom_range(0, 3)), 8'($urandom), 8, 1'b1);
      endcase
      check_regs("random");
    end

    repeat (5) @(negedge clk);
    check("wr_queue_drained", 16'(wr_exp_q.size()), 16'h0);
    check("rd_queue_drained", 16'(rd_exp_q.size()), 16'h0);
    check("dout_queue_drained", 16'(dout_exp_q.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tipi_reg_ctrl.md
TIPI_REG_CTRL -- requirements
Module: tipi_reg_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for every asynchronous input, minimum 2.
REQ-002 Parameter TD_ADDR, default 0x5FFF: TI write address of the TI-data register.
REQ-003 Parameter TC_ADDR, default 0x5FFD: TI write address of the TI-control register.
REQ-004 Parameter RD_ADDR, default 0x5FFB: TI read address of the RPi-data register.
REQ-005 Parameter RC_ADDR, default 0x5FF9: TI read address of the RPi-control register.
REQ-006 Port clk, in, 1: single system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-007 Port rst_n, in, 1: asynchronous, active-low reset.
REQ-008 Port ti_a, in, 16: TI address bus, bit 0 = MSB; asynchronous.
REQ-009 Port ti_data, in, 8: TI write data; asynchronous.
REQ-010 Ports ti_memen, ti_we, in, 1 each: active-low memory enable and write strobe; asynchronous.
REQ-011 Port ti_dbin, in, 1: active-high read strobe; asynchronous.
REQ-012 Port cru_en, in, 1: TIPI card enable; all TI-side access is ignored while 0.
REQ-013 Ports r_clk, r_le, r_din, in, 1 each: RPi shift clock, load strobe and serial data in; asynchronous.
REQ-014 Port r_reg, in, 2: RPi register select; 0=TD, 1=TC, 2=RD, 3=RC.
REQ-015 Port r_dout, out, 1: RPi serial data out.
REQ-016 Ports td_q, tc_q, rd_q, rc_q, out, 8 each: current register contents.
REQ-017 Ports ti_rd_data, out, 8 and ti_rd_oe, out, 1: TI read data and its output enable.
REQ-018 Port ti_wr_stb, out, 2: one-cycle write pulses; bit 0 = TD written, bit 1 = TC written.

Function
REQ-019 Every asynchronous input SHALL pass through a SYNC_STAGES flop synchronizer before use; ti_a and ti_data SHALL be registered alongside.
REQ-020 A TI write SHALL be detected on the cycle the synchronized ti_we shows a 1->0 edge while synchronized ti_memen=0 and cru_en=1.
REQ-021 Write detected and address == TD_ADDR: td_q <= registered ti_data on the next edge, and ti_wr_stb[0] pulses for exactly 1 cycle; TC_ADDR is handled likewise with tc_q and ti_wr_stb[1]; all other addresses are ignored.
REQ-022 Synchronized ti_memen=0, ti_dbin=1, cru_en=1 and address RD_ADDR or RC_ADDR: ti_rd_oe=1 with ti_rd_data=rd_q or rc_q, registered (1-cycle latency after synchronization); otherwise ti_rd_oe=0 and ti_rd_data=0x00.
REQ-023 RPi FSM states: IDLE, SHIFT, COMMIT.
REQ-024 Synchronized r_le 0->1 in any state: load shift register from the register selected by r_reg, clear bit count to 0, go to SHIFT; a load during SHIFT aborts the transfer in progress without committing.
REQ-025 SHIFT, synchronized r_clk 0->1: r_dout <= shift[7] (MSB first), shift <= {shift[6:0], r_din}, count++; when count reaches 8, go to COMMIT.
REQ-026 COMMIT, 1 cycle: r_reg=2 writes the shift register to rd_q; r_reg=3 writes it to rc_q; r_reg=0 or 1 leaves all registers unchanged; then go to IDLE.
REQ-027 r_clk edges in IDLE or COMMIT SHALL be ignored.
REQ-028 If a TI write to TD/TC and an RPi load of the same register occur in the same cycle, the load SHALL capture the old value.
REQ-029 If a COMMIT to RD/RC coincides with a TI read of that register, ti_rd_data SHALL show the new value from the following cycle.

Reset
REQ-030 While rst_n=0: td_q, tc_q, rd_q, rc_q, ti_rd_data = 0x00; ti_rd_oe = 0; r_dout = 0; ti_wr_stb = 0; FSM = IDLE; count = 0; synchronizers cleared to the inactive level (ti_we=1, ti_memen=1, ti_dbin=0, r_clk=0, r_le=0).
REQ-031 Reset asserted during SHIFT SHALL discard the transfer; no commit SHALL occur after release.

Structure
REQ-032 Shared package tipi_pkg SHALL hold the default register addresses, the r_reg encoding and the FSM state enum.
REQ-033 A single sub-module tipi_sync (parameterized-depth synchronizer with rise/fall pulse outputs) SHALL be instantiated once per asynchronous strobe.

Verification
REQ-034 TI write 0xA5 to 0x5FFF with cru_en=1 -> td_q=0xA5; ti_wr_stb=01 for exactly 1 cycle; tc_q unchanged.
REQ-035 TI write 0x3C to 0x5FFD with cru_en=0, then again with cru_en=1 -> tc_q stays 0x00, then becomes 0x3C.
REQ-036 RPi r_reg=2, load, shift in 0x81 with 8 r_clk pulses -> rd_q=0x81 after COMMIT; TI read of 0x5FFB -> ti_rd_oe=1, ti_rd_data=0x81.
REQ-037 td_q=0xC3, RPi r_reg=0, load plus 8 r_clk pulses -> r_dout sequence 1,1,0,0,0,0,1,1; td_q unchanged.
REQ-038 RPi r_reg=3, 4 r_clk pulses then a new load (or rst_n low) -> rc_q unchanged; the FSM restarts in SHIFT (or IDLE after reset).
